dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the core load/store unit, port 1 is the DMA/debug port.
- Each cycle, arbitrates between the two ports and converts the winner's (size, address, store data) into word address, byte enables and lane-shifted write data for the memory.
- Extracts and sign/zero-extends load data into a registered response.
- Sits between the LSU/DMA and the data memory, which reads combinationally and writes on the clock edge.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin; 1 = port 0 has priority, with anti-starvation for port 1.
- MAX_WAIT, 4: in FIXED_PRIO mode, consecutive cycles port 1 may be refused before it is forced to win (1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_i[2]  in  2  per-port request
- we_i[2]  in  2  per-port store (1) / load (0)
- size_i[2]  in  2x2  00 byte, 01 half, 10 word, 11 illegal
- uns_i[2]  in  2  load zero-extend (1) / sign-extend (0)
- addr_i[2]  in  2x32  byte address
- wdata_i[2]  in  2x32  store data, right-justified
- gnt_o[2]  out  2  request accepted this cycle (combinational)
- rvalid_o[2]  out  2  response valid, one cycle pulse
- err_o[2]  out  2  response is an error (qualifies rvalid_o)
- rdata_o  out  32  load data, extended; shared by both ports
- mem_we  out  1  memory write enable
- mem_be  out  4  memory byte enables
- mem_a  out  32  memory address, low 2 bits forced 0
- mem_wd  out  32  lane-aligned write data
- mem_rd  in  32  memory read data (combinational)

Behaviour:
- Reset (rst_n=0 at an edge):
  - rvalid_o=0, err_o=0, rdata_o=0.
  - Round-robin pointer = port 0; wait counter = 0.
  - Outputs are registered except gnt_o and mem_*.
- Arbitration (combinational from req_i and state):
  - At most one gnt_o bit set per cycle.
  - gnt_o=0 for both ports when neither requests.
  - A transfer occurs when req_i[p] & gnt_o[p].
- Round-robin (FIXED_PRIO=0):
  - If both request, the port not granted last wins.
  - The pointer updates only on a transfer.
  - A lone requester always wins.
- Fixed priority (FIXED_PRIO=1):
  - Port 0 wins ties.
  - The wait counter increments each cycle port 1 requests but is not granted, and clears when port 1 is granted or drops its request.
  - When counter == MAX_WAIT, port 1 wins regardless of port 0.
  - The counter saturates at MAX_WAIT.
- Alignment check:
  - Half with addr[0]=1, word with addr[1:0]!=0, or size=11 is misaligned.
  - Misaligned: transfer still granted; mem_we=0, mem_be=0.
  - Next cycle: rvalid_o[p]=1, err_o[p]=1, rdata_o=0.
- Memory drive (during a legal transfer, else mem_we=0, mem_be=0, mem_a=0, mem_wd=0):
  - mem_a = {addr[31:2], 2'b00}.
  - Byte: be = 0001 << addr[1:0]; wd = {4{wdata[7:0]}}.
  - Half: be = 0011 << addr[1:0]; wd = {2{wdata[15:0]}}.
  - Word: be = 1111; wd = wdata.
  - mem_we = we_i[p] for the granted port.
  - Loads also drive mem_be for visibility; the memory ignores it when mem_we=0.
- Response latency is 1 cycle after every transfer (load or store):
  - rvalid_o[p]=1 for exactly one cycle.
  - Loads: rdata_o = mem_rd shifted right by 8*addr[1:0], masked to size, then sign- or zero-extended per uns_i.
  - Stores: rdata_o=0.
  - With no transfer, rvalid_o=0 and rdata_o holds its previous value.
- Back-to-back: a new transfer may occur every cycle, including consecutive transfers to the same port. Requesters must accept responses unconditionally (no backpressure).
- Store then load to the same word in consecutive cycles returns the new data, because memory writes at the edge.
- Reset mid-operation: any pending response is dropped (rvalid_o=0 next cycle); no memory write occurs in a cycle where rst_n=0.

Test Plan:
- Reset, then port 0 word load at 0x10 with mem word 0xDEADBEEF -> gnt_o=01 same cycle; next cycle rvalid_o=01, err_o=0, rdata_o=0xDEADBEEF.
- Port 1 byte store 0x000000A5 at 0x23 -> mem_be=1000, mem_a=0x20, mem_wd=0xA5A5A5A5, mem_we=1. Then signed byte load at 0x23 -> rdata_o=0xFFFFFFA5; unsigned -> 0x000000A5.
- Half load at 0x12 with mem word 0x8001_7FFF, signed -> rdata_o=0xFFFF8001. Half load at 0x11 -> mem_be=0, err_o=1, rdata_o=0.
- FIXED_PRIO=0, both ports requesting continuously for 6 cycles -> grants alternate 01,10,01,10,01,10.
- FIXED_PRIO=1, MAX_WAIT=4, both requesting -> port 0 granted 4 cycles, port 1 granted on the 5th, then port 0 again; counter restarts.
- Store in cycle N to addr 0x40, reset asserted in cycle N+1 with a load pending -> no rvalid_o after reset; memory holds the cycle-N store data.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data memory: picks a winner each
// cycle, lane-aligns the access, and returns a registered, extended response.
module dmem_arbiter #(
   parameter int FIXED_PRIO = 0,
   parameter int MAX_WAIT   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_i,
   input  logic [1:0]       we_i,
   input  logic [1:0][1:0]  size_i,
   input  logic [1:0]       uns_i,
   input  logic [1:0][31:0] addr_i,
   input  logic [1:0][31:0] wdata_i,
   output logic [1:0]       gnt_o,
   output logic [1:0]       rvalid_o,
   output logic [1:0]       err_o,
   output logic [31:0]      rdata_o,
   output logic             mem_we,
   output logic [3:0]       mem_be,
   output logic [31:0]      mem_a,
   output logic [31:0]      mem_wd,
   input  logic [31:0]      mem_rd
);

   localparam logic [3:0] MAXW = 4'(MAX_WAIT);

   // rr_q names the port that wins the next tie
   logic        rr_q, rr_d;
   logic [3:0]  wait_q, wait_d;
   logic [1:0]  rvalid_q, rvalid_d;
   logic [1:0]  err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   logic        sel, xfer, mis, legal, force1;
   logic [1:0]  s;
   logic [31:0] a, w, sh, ext;
   logic [3:0]  be_raw;
   logic [31:0] wd_raw;

   always_comb begin
      force1 = (FIXED_PRIO != 0) && (wait_q == MAXW);
      gnt_o  = req_i;
      if (req_i == 2'b11) begin
         if (FIXED_PRIO != 0) gnt_o = force1 ? 2'b10 : 2'b01;
         else                 gnt_o = rr_q   ? 2'b10 : 2'b01;
      end
   end

   assign sel  = gnt_o[1];
   assign xfer = |gnt_o;
   assign s    = size_i[sel];
   assign a    = addr_i[sel];
   assign w    = wdata_i[sel];

   always_comb begin
      mis = 1'b0;
      case (s)
         2'b00: mis = 1'b0;
         2'b01: mis = a[0];
         2'b10: mis = |a[1:0];
         default: mis = 1'b1;
      endcase
   end

   // A cycle under reset never reaches the memory
   assign legal = xfer & ~mis & rst_n;

   always_comb begin
      be_raw = 4'b1111;
      wd_raw = w;
      case (s)
         2'b00: begin
            be_raw = 4'b0001 << a[1:0];
            wd_raw = {4{w[7:0]}};
         end
         2'b01: begin
            be_raw = 4'b0011 << a[1:0];
            wd_raw = {2{w[15:0]}};
         end
         default: ;
      endcase
   end

   assign mem_we = legal & we_i[sel];
   assign mem_be = legal ? be_raw : 4'b0000;
   assign mem_a  = legal ? {a[31:2], 2'b00} : 32'h0;
   assign mem_wd = legal ? wd_raw : 32'h0;

   assign sh = mem_rd >> {a[1:0], 3'b000};

   always_comb begin
      case (s)
         2'b00:   ext = {{24{~uns_i[sel] & sh[7]}}, sh[7:0]};
         2'b01:   ext = {{16{~uns_i[sel] & sh[15]}}, sh[15:0]};
         default: ext = sh;
      endcase
   end

   always_comb begin
      rr_d     = rr_q;
      wait_d   = 4'd0;
      rvalid_d = gnt_o;
      err_d    = mis ? gnt_o : 2'b00;
      rdata_d  = rdata_q;
      if (xfer) begin
         rr_d    = ~sel;
         rdata_d = (mis | we_i[sel]) ? 32'h0 : ext;
      end
      if ((FIXED_PRIO != 0) && req_i[1] && !gnt_o[1])
         wait_d = (wait_q == MAXW) ? wait_q : wait_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_q     <= 1'b0;
         wait_q   <= 4'd0;
         rvalid_q <= 2'b00;
         err_q    <= 2'b00;
         rdata_q  <= 32'h0;
      end else begin
         rr_q     <= rr_d;
         wait_q   <= wait_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign err_o    = err_q;
   assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed steps then random traffic against a
// byte-level memory model; a fixed-priority instance shares the inputs.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0]       req, we, uns;
   logic [1:0][1:0]  size;
   logic [1:0][31:0] addr, wdata;

   logic [1:0]  gnt0, rv0, err0, gnt1, rv1, err1;
   logic [31:0] rd0, rd1, ma0, ma1, mwd0, mwd1, mrd0;
   logic [31:0] mrd1;
   logic        mwe0, mwe1;
   logic [3:0]  mbe0, mbe1;

   assign mrd1 = 32'h0;

   dmem_arbiter #(.FIXED_PRIO(0), .MAX_WAIT(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .size_i(size), .uns_i(uns),
      .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt0), .rvalid_o(rv0), .err_o(err0),
      .rdata_o(rd0), .mem_we(mwe0), .mem_be(mbe0), .mem_a(ma0), .mem_wd(mwd0), .mem_rd(mrd0));

   dmem_arbiter #(.FIXED_PRIO(1), .MAX_WAIT(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .size_i(size), .uns_i(uns),
      .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt1), .rvalid_o(rv1), .err_o(err1),
      .rdata_o(rd1), .mem_we(mwe1), .mem_be(mbe1), .mem_a(ma1), .mem_wd(mwd1), .mem_rd(mrd1));

   // Memory attached to dut0: combinational read, byte-enabled write at the edge
   logic [31:0] mem [64];
   assign mrd0 = mem[ma0[7:2]];
   always @(posedge clk)
      if (mwe0)
         for (int b = 0; b < 4; b++)
            if (mbe0[b]) mem[ma0[7:2]][b*8 +: 8] <= mwd0[b*8 +: 8];

   logic [7:0] rmem [256];
   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req = 2'b00; we = 2'b00; uns = 2'b00;
      size = '0; addr = '0; wdata = '0;
   endtask

   task automatic set_port(input int p, input logic w, input logic [1:0] s, input logic u,
                           input logic [31:0] a, input logic [31:0] d);
      req[p] = 1'b1; we[p] = w; size[p] = s; uns[p] = u; addr[p] = a; wdata[p] = d;
   endtask

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic misal(input logic [31:0] a, input logic [1:0] s);
      return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input logic u);
      longint v = 0;
      int n = nbytes(s);
      for (int i = 0; i < n; i++) v = v | (longint'(rmem[a[7:0] + 8'(i)]) << (8 * i));
      if (!u && ((v >> (8 * n - 1)) & 1) == 1) v = v | (-64'sd1 << (8 * n));
      return 32'(v);
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
      for (int i = 0; i < nbytes(s); i++) rmem[a[7:0] + 8'(i)] = d[8*i +: 8];
   endtask

   logic [1:0]  exp_g0 [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
   logic [1:0]  exp_g1 [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

   int          rr_pref, wcnt, p, n;
   logic [1:0]  eg0, eg1, erv, eerr;
   logic [31:0] erd, ea, ewd;
   logic [3:0]  ebe;
   logic        m;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      for (int i = 0; i < 256; i++) rmem[i] = 8'h0;
      mem[4] <= 32'hDEADBEEF;
      rmem[16] = 8'hEF; rmem[17] = 8'hBE; rmem[18] = 8'hAD; rmem[19] = 8'hDE;

      idle();
      rst_n = 1'b0;
      tick(); tick();
      chk("reset_rvalid", rv0, 0);
      chk("reset_err", err0, 0);
      chk("reset_rdata", rd0, 0);
      chk("reset_rvalid_fp", rv1, 0);
      rst_n = 1'b1;

      // word load
      set_port(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      #1;
      chk("wload_gnt", gnt0, 2'b01);
      chk("wload_mem_a", ma0, 32'h10);
      chk("wload_mem_be", mbe0, 4'b1111);
      chk("wload_mem_we", mwe0, 0);
      tick();
      chk("wload_rvalid", rv0, 2'b01);
      chk("wload_err", err0, 0);
      chk("wload_rdata", rd0, 32'hDEADBEEF);

      // byte store from port 1, then signed/unsigned byte loads
      idle();
      set_port(1, 1'b1, 2'd0, 1'b0, 32'h23, 32'h000000A5);
      #1;
      chk("bst_gnt", gnt0, 2'b10);
      chk("bst_mem_be", mbe0, 4'b1000);
      chk("bst_mem_a", ma0, 32'h20);
      chk("bst_mem_wd", mwd0, 32'hA5A5A5A5);
      chk("bst_mem_we", mwe0, 1);
      ref_store(32'h23, 2'd0, 32'hA5);
      tick();
      chk("bst_rvalid", rv0, 2'b10);
      chk("bst_rdata", rd0, 0);
      idle();
      set_port(0, 1'b0, 2'd0, 1'b0, 32'h23, 32'h0);
      tick();
      chk("bld_signed", rd0, 32'hFFFFFFA5);
      set_port(0, 1'b0, 2'd0, 1'b1, 32'h23, 32'h0);
      tick();
      chk("bld_unsigned", rd0, 32'h000000A5);

      // half loads, aligned and misaligned
      idle();
      set_port(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h80017FFF);
      ref_store(32'h10, 2'd2, 32'h80017FFF);
      tick();
      idle();
      set_port(0, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
      tick();
      chk("hld_signed", rd0, 32'hFFFF8001);
      set_port(0, 1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
      #1;
      chk("hmis_gnt", gnt0, 2'b01);
      chk("hmis_mem_be", mbe0, 0);
      tick();
      chk("hmis_rvalid", rv0, 2'b01);
      chk("hmis_err", err0, 2'b01);
      chk("hmis_rdata", rd0, 0);

      // both ports requesting continuously from reset
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      set_port(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      set_port(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("rr_gnt%0d", i), gnt0, exp_g0[i]);
         chk($sformatf("fp_gnt%0d", i), gnt1, exp_g1[i]);
         tick();
      end

      // store, then reset while a load and a competing store are pending
      idle();
      set_port(0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678);
      ref_store(32'h40, 2'd2, 32'h12345678);
      #1;
      chk("rst_st_we", mwe0, 1);
      tick();
      chk("rst_st_rvalid", rv0, 2'b01);
      set_port(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
      set_port(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hBAD0BAD0);
      rst_n = 1'b0;
      #1;
      chk("rst_no_we", mwe0, 0);
      tick();
      chk("rst_drop_rvalid", rv0, 0);
      idle();
      rst_n = 1'b1;
      tick();
      chk("rst_idle_rvalid", rv0, 0);
      chk("rst_mem_word", mem[16], 32'h12345678);
      set_port(0, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
      tick();
      chk("rst_reload", rd0, 32'h12345678);

      // random traffic against the model, starting from a clean reset
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      rr_pref = 0; wcnt = 0; erd = 32'h0;
      for (int c = 0; c < 400; c++) begin
         for (int q = 0; q < 2; q++) begin
            req[q]   = ($urandom_range(0, 3) != 0);
            we[q]    = 1'($urandom_range(0, 1));
            uns[q]   = 1'($urandom_range(0, 1));
            size[q]  = 2'($urandom_range(0, 3));
            addr[q]  = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) addr[q] = addr[q] & ~32'd3;
            wdata[q] = $urandom;
         end
         if (req == 2'b11) begin
            eg0 = (rr_pref == 0) ? 2'b01 : 2'b10;
            eg1 = (wcnt == 4) ? 2'b10 : 2'b01;
         end else begin
            eg0 = req;
            eg1 = req;
         end
         #1;
         chk("rnd_gnt", gnt0, eg0);
         chk("rnd_fp_gnt", gnt1, eg1);
         ebe = 4'b0; ea = 32'h0; ewd = 32'h0; m = 1'b0;
         erv = eg0; eerr = 2'b00;
         if (eg0 != 2'b00) begin
            p = eg0[1] ? 1 : 0;
            m = misal(addr[p], size[p]);
            if (m) begin
               eerr = eg0;
               erd  = 32'h0;
            end else begin
               n   = nbytes(size[p]);
               ebe = 4'(((1 << n) - 1) << (addr[p] % 4));
               ea  = addr[p] & ~32'd3;
               ewd = (n == 1) ? {4{wdata[p][7:0]}} : (n == 2) ? {2{wdata[p][15:0]}} : wdata[p];
               if (we[p]) begin
                  erd = 32'h0;
                  ref_store(addr[p], size[p], wdata[p]);
               end else begin
                  erd = ref_load(addr[p], size[p], uns[p]);
               end
            end
            rr_pref = 1 - p;
         end
         chk("rnd_mem_we", mwe0, (eg0 != 2'b00) && !m && we[p]);
         chk("rnd_mem_be", mbe0, ebe);
         chk("rnd_mem_a", ma0, ea);
         chk("rnd_mem_wd", mwd0, ewd);
         if (req[1] && !eg1[1]) wcnt = (wcnt == 4) ? 4 : wcnt + 1;
         else wcnt = 0;
         tick();
         chk("rnd_rvalid", rv0, erv);
         chk("rnd_err", err0, eerr);
         chk("rnd_rdata", rd0, erd);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
